// File: rtl/gsim_pkg.sv
// Shared types and sizing for the Gauss-Seidel control sequencer.
// Widths are derived here so every file agrees on counter sizes.
package gsim_pkg;

   localparam int N_VARS   = 16;
   localparam int N_STAGES = 5;
   localparam int N_ROUNDS = 70;
   localparam int IDX_W    = $clog2(N_VARS);
   localparam int STG_W    = 3;
   localparam int RND_W    = $clog2(N_ROUNDS);

   typedef enum logic [1:0] {
      RECV = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage

// File: rtl/gsim_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and datapath/testbench.
// early_exit exists only when GSIM_CONV_EXIT_EN is defined.
interface gsim_seq_ctrl_if;
   import gsim_pkg::*;

   logic             in_en;
   logic             out_ready;
   logic             conv_ok;
   logic             b_we;
   logic [IDX_W-1:0] b_addr;
   logic             calc_en;
   logic [IDX_W-1:0] var_idx;
   logic [STG_W-1:0] stage;
   logic             ans_we;
   logic             out_valid;
   logic [IDX_W-1:0] out_idx;
   logic [RND_W-1:0] round;
   logic             busy;
`ifdef GSIM_CONV_EXIT_EN
   logic             early_exit;
`endif

   modport master (
      input  in_en, out_ready, conv_ok,
      output b_we, b_addr, calc_en, var_idx, stage, ans_we,
             out_valid, out_idx, round, busy
`ifdef GSIM_CONV_EXIT_EN
      , output early_exit
`endif
   );

   modport slave (
      output in_en, out_ready, conv_ok,
      input  b_we, b_addr, calc_en, var_idx, stage, ans_we,
             out_valid, out_idx, round, busy
`ifdef GSIM_CONV_EXIT_EN
      , input early_exit
`endif
   );

endinterface

// File: rtl/gsim_wrap_cnt.sv
// Modulo-MAX counter with enable, sync clear and a wrap pulse; wrap is
// asserted combinationally in the enabled cycle that rolls MAX-1 over to 0.
module gsim_wrap_cnt #(
   parameter int MAX = 16,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap = en && (cnt_q == W'(MAX - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (wrap)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/gsim_seq_ctrl.sv
// Gauss-Seidel sequencer: load offsets, sweep stage/var/round, stream results.
// Optional convergence early exit under GSIM_CONV_EXIT_EN; SEND stalls on out_ready.
module gsim_seq_ctrl
   import gsim_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   gsim_seq_ctrl_if.master        io
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ld_q, ld_d;
   logic [IDX_W-1:0] snd_q, snd_d;

   logic             in_calc;
   logic             cnt_clr;
   logic             exit_now;
   logic             stage_wrap, var_wrap, round_wrap;
   logic [STG_W-1:0] stage_cnt;
   logic [IDX_W-1:0] var_cnt;
   logic [RND_W-1:0] round_cnt;

   assign in_calc = (state_q == CALC);
   // Clearing on the exit cycle leaves every sweep counter at 0 for SEND.
   assign cnt_clr = !in_calc || exit_now;

   gsim_wrap_cnt #(.MAX(N_STAGES), .W(STG_W)) u_stage (
      .clk(clk), .reset(reset), .en(in_calc), .clr(cnt_clr),
      .cnt(stage_cnt), .wrap(stage_wrap)
   );

   gsim_wrap_cnt #(.MAX(N_VARS), .W(IDX_W)) u_var (
      .clk(clk), .reset(reset), .en(stage_wrap), .clr(cnt_clr),
      .cnt(var_cnt), .wrap(var_wrap)
   );

   gsim_wrap_cnt #(.MAX(N_ROUNDS), .W(RND_W)) u_round (
      .clk(clk), .reset(reset), .en(var_wrap), .clr(cnt_clr),
      .cnt(round_cnt), .wrap(round_wrap)
   );

`ifdef GSIM_CONV_EXIT_EN
   logic all_conv_q, all_conv_d;
   logic early_q, early_d;
   logic early_hit;

   // The closing update of a round counts toward that round's convergence.
   assign early_hit = var_wrap && (round_cnt != '0) && all_conv_q && io.conv_ok;
   assign exit_now  = round_wrap || early_hit;

   always_comb begin
      all_conv_d = all_conv_q;
      early_d    = early_q;
      if (!in_calc || var_wrap)
         all_conv_d = 1'b1;
      else if (stage_wrap)
         all_conv_d = all_conv_q && io.conv_ok;
      if (in_calc && early_hit)
         early_d = 1'b1;
      if (state_d == RECV)
         early_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         all_conv_q <= 1'b0;
         early_q    <= 1'b0;
      end else begin
         all_conv_q <= all_conv_d;
         early_q    <= early_d;
      end
   end

   assign io.early_exit = early_q;
`else
   logic unused_conv_ok;
   assign unused_conv_ok = io.conv_ok;
   assign exit_now       = round_wrap;
`endif

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      snd_d   = snd_q;
      case (state_q)
         RECV: begin
            if (io.in_en) begin
               if (ld_q == IDX_W'(N_VARS - 1)) begin
                  ld_d    = '0;
                  state_d = CALC;
               end else begin
                  ld_d = ld_q + IDX_W'(1);
               end
            end
         end
         CALC: begin
            if (exit_now)
               state_d = SEND;
         end
         SEND: begin
            if (io.out_ready) begin
               if (snd_q == IDX_W'(N_VARS - 1)) begin
                  snd_d   = '0;
                  state_d = RECV;
               end else begin
                  snd_d = snd_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = RECV;
            ld_d    = '0;
            snd_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RECV;
         ld_q    <= '0;
         snd_q   <= '0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         snd_q   <= snd_d;
      end
   end

   assign io.b_we      = (state_q == RECV) && io.in_en;
   assign io.b_addr    = ld_q;
   assign io.calc_en   = in_calc;
   assign io.var_idx   = var_cnt;
   assign io.stage     = stage_cnt;
   assign io.ans_we    = stage_wrap;
   assign io.round     = round_cnt;
   assign io.out_valid = (state_q == SEND);
   assign io.out_idx   = snd_q;
   assign io.busy      = (state_q != RECV);

endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// Directed bench for gsim_seq_ctrl: load, full sweep, stalled send, async abort.
// Early-exit checks compile in only with GSIM_CONV_EXIT_EN.
module tb_gsim_seq_ctrl;
   import gsim_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gsim_seq_ctrl_if bus();

   gsim_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int exp_q[$];
   int exp_ld      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_calc_en"},   32'(bus.calc_en),   0);
      chk({tag, "_ans_we"},    32'(bus.ans_we),    0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_busy"},      32'(bus.busy),      0);
      chk({tag, "_b_addr"},    32'(bus.b_addr),    0);
      chk({tag, "_var_idx"},   32'(bus.var_idx),   0);
      chk({tag, "_stage"},     32'(bus.stage),     0);
      chk({tag, "_round"},     32'(bus.round),     0);
      chk({tag, "_out_idx"},   32'(bus.out_idx),   0);
   endtask

   task automatic load(input int nwords);
      for (int i = 0; i < nwords; i++) begin
         @(negedge clk);
         bus.in_en = 1'b1;
         exp_q.push_back(exp_ld);
         exp_ld = (exp_ld + 1) % N_VARS;
         #1;
         chk("b_we", 32'(bus.b_we), 1);
         chk("b_addr", 32'(bus.b_addr), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic idle(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         bus.in_en = 1'b0;
         #1;
         chk("gap_b_we", 32'(bus.b_we), 0);
         chk("gap_b_addr", 32'(bus.b_addr), 32'(exp_ld));
      end
   endtask

   task automatic enter_calc();
      @(negedge clk);
      bus.in_en = 1'b0;
      #1;
      chk("calc_entry_calc_en", 32'(bus.calc_en), 1);
      chk("calc_entry_busy",    32'(bus.busy),    1);
      chk("calc_entry_var_idx", 32'(bus.var_idx), 0);
      chk("calc_entry_stage",   32'(bus.stage),   0);
      chk("calc_entry_round",   32'(bus.round),   0);
   endtask

   task automatic run_calc(output int cyc, output int we, output int maxr, output int bad);
      cyc = 0; we = 0; maxr = 0; bad = 0;
      while (bus.calc_en === 1'b1 && cyc < 8000) begin
         cyc++;
         if (bus.ans_we === 1'b1) begin
            we++;
            if (bus.stage !== 3'(N_STAGES - 1)) bad++;
         end
         if (int'(bus.round) > maxr) maxr = int'(bus.round);
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send_all();
      int k;
      for (int i = 0; i < N_VARS; i++) exp_q.push_back(i);
      k = 0;
      while (exp_q.size() > 0 && k < 200) begin
         chk("send_out_valid", 32'(bus.out_valid), 1);
         chk("send_out_idx", 32'(bus.out_idx), 32'(exp_q[0]));
         bus.out_ready = (k % 3 == 0);
         if (bus.out_ready) void'(exp_q.pop_front());
         k++;
         @(negedge clk);
         #1;
      end
      chk("send_all_accepted", 32'(exp_q.size()), 0);
      exp_q.delete();
      bus.out_ready = 1'b0;
      chk("post_send_out_valid", 32'(bus.out_valid), 0);
      chk("post_send_busy",      32'(bus.busy),      0);
      chk("post_send_out_idx",   32'(bus.out_idx),   0);
   endtask

   initial begin
      int cyc, we, maxr, bad;
      reset         = 1'b0;
      bus.in_en     = 1'b0;
      bus.out_ready = 1'b0;
      bus.conv_ok   = 1'b0;
      #12;
      chk_idle_outputs("reset");
      chk("reset_b_we", 32'(bus.b_we), 0);
      @(negedge clk);
      reset = 1'b1;

      // Back-to-back load, full 70-round sweep, stalled result stream.
      exp_ld = 0;
      load(N_VARS);
      enter_calc();
      run_calc(cyc, we, maxr, bad);
      chk("calc_cycles", 32'(cyc), 32'(N_VARS * N_STAGES * N_ROUNDS));
      chk("ans_we_pulses", 32'(we), 32'(N_VARS * N_ROUNDS));
      chk("ans_we_off_stage", 32'(bad), 0);
      chk("max_round", 32'(maxr), 32'(N_ROUNDS - 1));
      send_all();

      // Gapped load, then asynchronous abort partway through the sweep.
      load(5);
      idle(3);
      load(11);
      enter_calc();
      repeat (2000) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk_idle_outputs("abort");
      @(negedge clk);
      reset = 1'b1;
      exp_ld = 0;
      load(N_VARS);
      enter_calc();

`ifdef GSIM_CONV_EXIT_EN
      bus.conv_ok = 1'b1;
      run_calc(cyc, we, maxr, bad);
      chk("early_calc_cycles", 32'(cyc), 32'(2 * N_VARS * N_STAGES));
      chk("early_exit_set", 32'(bus.early_exit), 1);
      send_all();
      chk("early_exit_clear", 32'(bus.early_exit), 0);
      bus.conv_ok = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
